// File: rtl/mini_fifo_reader_if.sv
// Bundles the FIFO read port and the output stream of the drain engine.
// The master side is the reader; the slave side is the FIFO plus downstream sink.
interface mini_fifo_reader_if #(
    parameter int N       = 8,
    parameter int PKT_LEN = 4
);
    // FIFO read side
    logic                          fifo_empty;
    logic [N-1:0]                  fifo_out;
    logic                          fifo_rd;
    // Output stream
    logic                          out_valid;
    logic                          out_ready;
    logic [N-1:0]                  out_data;
    logic                          out_last;
    // Packet statistics
    logic [N+$clog2(PKT_LEN)-1:0]  pkt_sum;
    logic                          sum_valid;
    logic [7:0]                    pkt_count;

    modport master (
        input  fifo_empty, fifo_out, out_ready,
        output fifo_rd, out_valid, out_data, out_last, pkt_sum, sum_valid, pkt_count
    );

    modport slave (
        output fifo_empty, fifo_out, out_ready,
        input  fifo_rd, out_valid, out_data, out_last, pkt_sum, sum_valid, pkt_count
    );
endinterface

// File: rtl/mini_fifo_reader.sv
// Drains the result FIFO one word at a time, re-presents each word on a
// valid/ready stream, marks the last beat of each PKT_LEN-word packet and
// publishes a per-packet checksum plus a completed-packet counter.
module mini_fifo_reader #(
    parameter int N       = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    mini_fifo_reader_if.master     bus
);
    localparam int BW = $clog2(PKT_LEN);
    localparam int SW = N + BW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

    state_t          state_q, state_d;
    logic            fifo_rd_q, fifo_rd_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic [SW-1:0]   pkt_sum_q, pkt_sum_d;
    logic            sum_valid_q, sum_valid_d;
    logic [7:0]      pkt_count_q, pkt_count_d;
    logic            start_rd;

    // A new pop is only started when the FIFO reports data in this very cycle,
    // which is what keeps the FIFO from underflowing.
    assign start_rd = enable && !bus.fifo_empty;

    // Next-state, datapath and checksum; outputs are decoded from the next
    // state so they come straight out of flops.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        beat_d      = beat_q;
        acc_d       = acc_q;
        pkt_sum_d   = pkt_sum_q;
        pkt_count_d = pkt_count_q;
        sum_valid_d = 1'b0;
        case (state_q)
            IDLE: if (start_rd) state_d = RD;
            RD:   state_d = CAP;
            CAP: begin
                out_data_d = bus.fifo_out;
                out_last_d = (beat_q == LAST_BEAT);
                state_d    = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        pkt_sum_d   = acc_q + SW'(out_data_q);
                        sum_valid_d = 1'b1;
                        acc_d       = '0;
                        beat_d      = '0;
                        pkt_count_d = pkt_count_q + 8'd1;
                    end else begin
                        acc_d  = acc_q + SW'(out_data_q);
                        beat_d = beat_q + 1'b1;
                    end
                    out_last_d = 1'b0;
                    state_d    = start_rd ? RD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        fifo_rd_d   = (state_d == RD);
        out_valid_d = (state_d == SEND);
    end

    // All state and registered outputs; reset clears everything immediately,
    // discarding any partial packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fifo_rd_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            beat_q      <= '0;
            acc_q       <= '0;
            pkt_sum_q   <= '0;
            sum_valid_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fifo_rd_q   <= fifo_rd_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            beat_q      <= beat_d;
            acc_q       <= acc_d;
            pkt_sum_q   <= pkt_sum_d;
            sum_valid_q <= sum_valid_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign bus.fifo_rd   = fifo_rd_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.pkt_sum   = pkt_sum_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.pkt_count = pkt_count_q;
endmodule

// File: tb/tb_mini_fifo_reader.sv
// Directed bench for mini_fifo_reader: a small FIFO model feeds the reader,
// a posedge monitor logs pops, handshakes and checksum pulses, and the main
// sequence compares those logs against hand-computed values.
module tb_mini_fifo_reader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    mini_fifo_reader_if #(.N(8), .PKT_LEN(4)) bus ();

    mini_fifo_reader #(.N(8), .PKT_LEN(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus.master)
    );

    // FIFO model: pushes come from the sequence, pops on sampled fifo_rd
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] fifo_out_r = 8'h00;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_out   = fifo_out_r;

    always @(posedge clk) begin
        if (bus.fifo_rd && (rd_ptr != wr_ptr)) begin
            fifo_out_r <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Monitor logs
    int         cyc = 0;
    int         rd_cnt = 0, hs_cnt = 0, sum_cnt = 0, vr_cnt = 0, underflow = 0;
    int         rd_cyc [0:63];
    int         vr_cyc [0:63];
    logic [7:0] hs_data [0:63];
    logic       hs_last [0:63];
    logic [9:0] sum_log [0:63];
    logic       vprev = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd) begin
            rd_cyc[rd_cnt] <= cyc;
            rd_cnt         <= rd_cnt + 1;
            if (rd_ptr == wr_ptr) underflow <= underflow + 1;
        end
        if (bus.out_valid && bus.out_ready) begin
            hs_data[hs_cnt] <= bus.out_data;
            hs_last[hs_cnt] <= bus.out_last;
            hs_cnt          <= hs_cnt + 1;
        end
        if (bus.sum_valid) begin
            sum_log[sum_cnt] <= bus.pkt_sum;
            sum_cnt          <= sum_cnt + 1;
        end
        if (bus.out_valid && !vprev) begin
            vr_cyc[vr_cnt] <= cyc;
            vr_cnt         <= vr_cnt + 1;
        end
        vprev <= bus.out_valid;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 1;
    endtask

    task automatic wait_hs(input int target, input string tag);
        int n = 0;
        while (hs_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(hs_cnt >= target), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    int rb, hb, sb, vb, c0, n;
    logic [3:0] lastbits;

    initial begin
        bus.out_ready = 1'b0;
        // ---------------- reset state
        tick(3);
        check("rst_fifo_rd",   32'(bus.fifo_rd),   32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_pkt_sum",   32'(bus.pkt_sum),   32'd0);
        check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
        rst = 1'b1;
        tick(1);

        // ---------------- one packet 1,2,3,4
        rb = rd_cnt; hb = hs_cnt; sb = sum_cnt; vb = vr_cnt;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        enable = 1'b1; bus.out_ready = 1'b1;
        wait_hs(hb + 4, "p1_done");
        tick(3);
        for (int i = 0; i < 4; i++) check("p1_data", 32'(hs_data[hb+i]), 32'(i + 1));
        lastbits = {hs_last[hb+3], hs_last[hb+2], hs_last[hb+1], hs_last[hb]};
        check("p1_last", 32'(lastbits), 32'h8);
        check("p1_sum_cnt", 32'(sum_cnt - sb), 32'd1);
        check("p1_sum", 32'(sum_log[sb]), 32'h00A);
        check("p1_pkt_sum", 32'(bus.pkt_sum), 32'h00A);
        check("p1_pkt_count", 32'(bus.pkt_count), 32'd1);
        check("p1_rd_cnt", 32'(rd_cnt - rb), 32'd4);
        for (int i = 0; i < 3; i++) check("p1_rd_gap", 32'(rd_cyc[rb+i+1] - rd_cyc[rb+i]), 32'd3);
        check("p1_latency", 32'(vr_cyc[vb] - rd_cyc[rb]), 32'd2);

        // ---------------- all-ones packet, checksum headroom
        do_reset();
        sb = sum_cnt; hb = hs_cnt;
        for (int i = 0; i < 4; i++) push(8'hFF);
        wait_hs(hb + 4, "p2_done");
        tick(3);
        check("p2_sum", 32'(sum_log[sb]), 32'h3FC);
        check("p2_pkt_count", 32'(bus.pkt_count), 32'd1);

        // ---------------- backpressure holds the word
        do_reset();
        rb = rd_cnt; hb = hs_cnt;
        bus.out_ready = 1'b0;
        push(8'h11); push(8'h22);
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(1); n++; end
        check("bp_valid_rise", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("bp_data_hold", 32'(bus.out_data), 32'h11);
            check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            tick(1);
        end
        check("bp_one_rd", 32'(rd_cnt - rb), 32'd1);
        bus.out_ready = 1'b1;
        wait_hs(hb + 2, "bp_done");
        check("bp_first", 32'(hs_data[hb]), 32'h11);
        check("bp_second", 32'(hs_data[hb+1]), 32'h22);

        // ---------------- empty FIFO, then a late push
        do_reset();
        rb = rd_cnt; vb = vr_cnt;
        tick(20);
        check("empty_no_rd", 32'(rd_cnt - rb), 32'd0);
        check("empty_no_valid", 32'(vr_cnt - vb), 32'd0);
        c0 = cyc;
        push(8'h05);
        tick(6);
        check("late_rd_cnt", 32'(rd_cnt - rb), 32'd1);
        check("late_rd_cyc", 32'(rd_cyc[rb] - c0), 32'd1);
        check("late_valid_cyc", 32'(vr_cyc[vb] - rd_cyc[rb]), 32'd2);

        // ---------------- two packets with an enable gap
        do_reset();
        rb = rd_cnt; hb = hs_cnt; sb = sum_cnt;
        for (int i = 1; i <= 8; i++) push(8'(i));
        n = 0;
        while (!(bus.out_valid && bus.out_data == 8'h02) && n < 40) begin tick(1); n++; end
        check("gap_word2_seen", 32'(bus.out_valid), 32'd1);
        enable = 1'b0;
        tick(10);
        check("gap_rd_cnt", 32'(rd_cnt - rb), 32'd2);
        check("gap_hs_cnt", 32'(hs_cnt - hb), 32'd2);
        check("gap_no_sum", 32'(sum_cnt - sb), 32'd0);
        enable = 1'b1;
        wait_hs(hb + 8, "gap_done");
        tick(3);
        for (int i = 0; i < 8; i++) check("gap_data", 32'(hs_data[hb+i]), 32'(i + 1));
        check("gap_sum_cnt", 32'(sum_cnt - sb), 32'd2);
        check("gap_sum0", 32'(sum_log[sb]), 32'h00A);
        check("gap_sum1", 32'(sum_log[sb+1]), 32'h01A);
        check("gap_pkt_count", 32'(bus.pkt_count), 32'd2);

        // ---------------- asynchronous reset mid-packet
        do_reset();
        hb = hs_cnt; sb = sum_cnt;
        push(8'h01); push(8'h02); push(8'h03);
        n = 0;
        while (!(bus.out_valid && hs_cnt == hb + 2) && n < 40) begin tick(1); n++; end
        check("ar_in_send", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("ar_valid_low", 32'(bus.out_valid), 32'd0);
        check("ar_rd_low", 32'(bus.fifo_rd), 32'd0);
        check("ar_last_low", 32'(bus.out_last), 32'd0);
        tick(2);
        check("ar_no_sum", 32'(sum_cnt - sb), 32'd0);
        rst = 1'b1;
        hb = hs_cnt;
        for (int i = 0; i < 4; i++) push(8'h09);
        wait_hs(hb + 4, "ar_done");
        tick(3);
        check("ar_sum", 32'(sum_log[sb]), 32'h024);
        check("ar_pkt_count", 32'(bus.pkt_count), 32'd1);

        check("no_underflow", 32'(underflow), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
